// File: rtl/cp0_timer_ctrl.sv
// cp0_timer_ctrl: CP0 Count/Compare pair and MIPS timer interrupt (IP7).
// Optional: define CP0_TIMER_FREEZE_EN to let freeze hold tick and Count.
module cp0_timer_ctrl #(
  parameter logic [31:0] COUNT_INI    = 32'h0000_0000,
  parameter logic [31:0] COMPARE_INI  = 32'hFFFF_FFFF,
  parameter logic [5:0]  ADDR_COUNT   = 6'd9,
  parameter logic [5:0]  ADDR_COMPARE = 6'd11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mtc0_we,
  input  logic [5:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic        status_im7,
  input  logic        freeze,
  output logic [31:0] rdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        cause_ti,
  output logic        timer_irq
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    PENDING  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        tick_q;
  logic        tick_d;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic [31:0] compare_q;
  logic [31:0] compare_d;
  logic        ti_q;
  logic        ti_d;

  logic        wr_count;
  logic        wr_compare;
  logic        match;
  logic        run;
  logic        inc;
  logic        sel_count;
  logic        sel_compare;

  assign sel_count   = (cp0_addr == ADDR_COUNT);
  assign sel_compare = (cp0_addr == ADDR_COMPARE);
  assign wr_count    = mtc0_we && sel_count;
  assign wr_compare  = mtc0_we && sel_compare;
  assign match       = (count_q == compare_q);

`ifdef CP0_TIMER_FREEZE_EN
  assign run = ~freeze;
`else
  logic unused_freeze;
  assign unused_freeze = freeze;
  assign run = 1'b1;
`endif

  // Count only advances on the odd half of the divide-by-two phase
  assign inc = run & tick_q;

  // Tick phase: a Count write restarts the phase so the
  // freshly written value is held for two full cycles
  always_comb begin
    tick_d = tick_q;
    if (wr_count) begin
      tick_d = 1'b0;
    end else if (run) begin
      tick_d = ~tick_q;
    end
  end

  // Count: software write beats the free-running increment
  always_comb begin
    count_d = count_q;
    if (wr_count) begin
      count_d = mtc0_data;
    end else if (inc) begin
      count_d = count_q + 32'd1;
    end
  end

  // Compare: plain software-written register
  always_comb begin
    compare_d = compare_q;
    if (wr_compare) begin
      compare_d = mtc0_data;
    end
  end

  // Arming FSM: a Compare write always re-arms and clears TI,
  // even when it lands on the match cycle
  always_comb begin
    state_d = state_q;
    ti_d    = ti_q;
    unique case (state_q)
      DISARMED: begin
        if (wr_compare) begin
          state_d = ARMED;
          ti_d    = 1'b0;
        end
      end
      ARMED: begin
        if (wr_compare) begin
          state_d = ARMED;
          ti_d    = 1'b0;
        end else if (match) begin
          state_d = PENDING;
          ti_d    = 1'b1;
        end
      end
      PENDING: begin
        if (wr_compare) begin
          state_d = ARMED;
          ti_d    = 1'b0;
        end
      end
      default: begin
        state_d = DISARMED;
        ti_d    = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DISARMED;
      tick_q    <= 1'b0;
      count_q   <= COUNT_INI;
      compare_q <= COMPARE_INI;
      ti_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  // MFC0 read mux
  always_comb begin
    rdata = 32'h0;
    unique case (1'b1)
      sel_count:   rdata = count_q;
      sel_compare: rdata = compare_q;
      default:     rdata = 32'h0;
    endcase
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign cause_ti  = ti_q;
  assign timer_irq = ti_q & status_ie & ~status_exl & status_im7;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// tb_cp0_timer_ctrl: directed scoreboard bench for cp0_timer_ctrl.
// Covers reset, divide-by-two count, match/arming, wrap and collisions.
module tb_cp0_timer_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mtc0_we;
  logic [5:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic        status_ie;
  logic        status_exl;
  logic        status_im7;
  logic        freeze;
  logic [31:0] rdata;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic        cause_ti;
  logic        timer_irq;

  int          nvec;
  int          nmis;
  string       tq[$];
  logic [31:0] vq[$];

  cp0_timer_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mtc0_we    (mtc0_we),
    .cp0_addr   (cp0_addr),
    .mtc0_data  (mtc0_data),
    .status_ie  (status_ie),
    .status_exl (status_exl),
    .status_im7 (status_im7),
    .freeze     (freeze),
    .rdata      (rdata),
    .count_o    (count_o),
    .compare_o  (compare_o),
    .cause_ti   (cause_ti),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic exp(input string t, input logic [31:0] v);
    tq.push_back(t);
    vq.push_back(v);
  endtask

  task automatic cmp(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    nvec++;
    if (vq.size() == 0) begin
      nmis++;
      $error("FAIL sb_empty observed=%h", obs);
    end else begin
      t = tq.pop_front();
      e = vq.pop_front();
      assert (obs === e) else begin
        nmis++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    mtc0_we   = 1'b1;
    cp0_addr  = a;
    mtc0_data = d;
    step(1);
    mtc0_we   = 1'b0;
  endtask

  initial begin
    nvec       = 0;
    nmis       = 0;
    rst_n      = 1'b0;
    mtc0_we    = 1'b0;
    cp0_addr   = 6'd0;
    mtc0_data  = 32'h0;
    status_ie  = 1'b1;
    status_exl = 1'b0;
    status_im7 = 1'b1;
    freeze     = 1'b0;

    // reset state
    exp("rst_count", 32'h0);
    exp("rst_compare", 32'hFFFF_FFFF);
    exp("rst_ti", 32'h0);
    exp("rst_irq", 32'h0);
    exp("rst_rdata_other", 32'h0);
    step(2);
    rst_n = 1'b1;
    cmp(count_o);
    cmp(compare_o);
    cmp({31'h0, cause_ti});
    cmp({31'h0, timer_irq});
    cmp(rdata);

    // 10 idle cycles -> Count=5
    exp("idle_count", 32'd5);
    exp("idle_ti", 32'h0);
    exp("idle_rdata", 32'd5);
    cp0_addr = 6'd9;
    step(10);
    cmp(count_o);
    cmp({31'h0, cause_ti});
    cmp(rdata);

    // DISARMED ignores Count==Compare, and FFFF_FFFF wraps
    exp("disarmed_ti", 32'h0);
    exp("disarmed_wrap", 32'h0);
    wr(6'd9, 32'hFFFF_FFFF);
    step(2);
    cmp({31'h0, cause_ti});
    cmp(count_o);

    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;

    // Compare=8 from Count=0 tick=0
    exp("c8_pre_ti", 32'h0);
    exp("c8_pre_count", 32'd8);
    wr(6'd11, 32'd8);
    step(15);
    cmp({31'h0, cause_ti});
    cmp(count_o);
    exp("c8_fire", 32'h1);
    exp("irq_on", 32'h1);
    step(1);
    cmp({31'h0, cause_ti});
    cmp({31'h0, timer_irq});
    exp("ti_hold", 32'h1);
    exp("ti_hold_count", 32'd10);
    step(4);
    cmp({31'h0, cause_ti});
    cmp(count_o);
    exp("irq_exl", 32'h0);
    status_exl = 1'b1;
    #1;
    cmp({31'h0, timer_irq});
    exp("irq_im7", 32'h0);
    status_exl = 1'b0;
    status_im7 = 1'b0;
    #1;
    cmp({31'h0, timer_irq});
    exp("irq_ie", 32'h0);
    status_im7 = 1'b1;
    status_ie  = 1'b0;
    #1;
    cmp({31'h0, timer_irq});
    status_ie = 1'b1;

    // re-arm with Compare=20, then Count=20
    exp("rearm_ti", 32'h0);
    exp("rearm_rdata", 32'd20);
    wr(6'd11, 32'd20);
    cmp({31'h0, cause_ti});
    cmp(rdata);
    exp("cw20_ti", 32'h0);
    exp("cw20_count", 32'd20);
    wr(6'd9, 32'd20);
    cmp({31'h0, cause_ti});
    cmp(count_o);
    exp("cw20_fire", 32'h1);
    exp("cw20_hold", 32'd20);
    step(1);
    cmp({31'h0, cause_ti});
    cmp(count_o);

    // wrap through zero to Compare=1
    exp("wrap_arm_ti", 32'h0);
    wr(6'd11, 32'd1);
    cmp({31'h0, cause_ti});
    exp("wrap_fe", 32'hFFFF_FFFE);
    wr(6'd9, 32'hFFFF_FFFE);
    cmp(count_o);
    exp("wrap_ff", 32'hFFFF_FFFF);
    step(2);
    cmp(count_o);
    exp("wrap_0", 32'h0);
    step(2);
    cmp(count_o);
    exp("wrap_1", 32'h1);
    exp("wrap_1_ti", 32'h0);
    step(2);
    cmp(count_o);
    cmp({31'h0, cause_ti});
    exp("wrap_fire", 32'h1);
    step(1);
    cmp({31'h0, cause_ti});

    // Compare write on the match cycle wins
    wr(6'd11, 32'd50);
    wr(6'd9, 32'd50);
    exp("coll_ti", 32'h0);
    wr(6'd11, 32'd50);
    cmp({31'h0, cause_ti});
    exp("coll_refire", 32'h1);
    exp("coll_count", 32'd51);
    step(1);
    cmp({31'h0, cause_ti});
    cmp(count_o);

    // Count write with tick=1 beats the increment
    step(1);
    exp("cw_t1", 32'd100);
    wr(6'd9, 32'd100);
    cmp(count_o);
    exp("cw_t1_hold", 32'd100);
    step(1);
    cmp(count_o);
    exp("cw_t1_inc", 32'd101);
    step(1);
    cmp(count_o);

    // Count write with tick=0 restarts the phase
    exp("cw_t0", 32'd200);
    wr(6'd9, 32'd200);
    cmp(count_o);
    exp("cw_t0_hold", 32'd200);
    step(1);
    cmp(count_o);
    exp("cw_t0_inc", 32'd201);
    step(1);
    cmp(count_o);

    // reset overrides PENDING and a same-cycle write
    exp("pend_before_rst", 32'h1);
    cmp({31'h0, cause_ti});
    exp("mid_rst_count", 32'h0);
    exp("mid_rst_compare", 32'hFFFF_FFFF);
    exp("mid_rst_ti", 32'h0);
    rst_n     = 1'b0;
    mtc0_we   = 1'b1;
    cp0_addr  = 6'd9;
    mtc0_data = 32'd123;
    step(1);
    mtc0_we = 1'b0;
    rst_n   = 1'b1;
    cmp(count_o);
    cmp(compare_o);
    cmp({31'h0, cause_ti});

    // freeze from Count=3 tick=0
    exp("frz_start", 32'd3);
    step(6);
    cmp(count_o);
    freeze = 1'b1;
`ifdef CP0_TIMER_FREEZE_EN
    exp("frz_hold", 32'd3);
    step(7);
    cmp(count_o);
    exp("frz_write", 32'd40);
    wr(6'd9, 32'd40);
    cmp(count_o);
    exp("frz_arm_ti", 32'h0);
    wr(6'd11, 32'd40);
    cmp({31'h0, cause_ti});
    exp("frz_match", 32'h1);
    exp("frz_match_count", 32'd40);
    step(1);
    cmp({31'h0, cause_ti});
    cmp(count_o);
    freeze = 1'b0;
    exp("frz_rel_hold", 32'd40);
    step(1);
    cmp(count_o);
    exp("frz_rel_inc", 32'd41);
    step(1);
    cmp(count_o);
`else
    exp("frz_ignored", 32'd6);
    step(7);
    cmp(count_o);
    exp("frz_ign_write", 32'd40);
    wr(6'd9, 32'd40);
    cmp(count_o);
    exp("frz_ign_inc", 32'd41);
    step(2);
    cmp(count_o);
    freeze = 1'b0;
`endif

    nvec++;
    if (vq.size() != 0) begin
      nmis++;
      $display("FAIL sb_leftover observed=%0d expected=0", vq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/cp0_timer_ctrl.md
Name: cp0_timer_ctrl

Overview:
- Owns the CP0 Count/Compare pair and sequences the MIPS timer interrupt.
- Count advances at half the core clock. A Compare match raises Cause.TI (hardware interrupt line 5, IP7). TI stays set until software rewrites Compare.
- Sits inside the CP0 block, beside the Status/Cause logic. Arbitrates MTC0 writes against the free-running increment and drives the masked timer request to the exception unit.

Parameters:
- COUNT_INI, 32'h0000_0000, Count value after reset.
- COMPARE_INI, 32'hFFFF_FFFF, Compare value after reset.
- ADDR_COUNT, 6'd9, cp0_addr code selecting Count.
- ADDR_COMPARE, 6'd11, cp0_addr code selecting Compare.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, synchronous, active-low.
- mtc0_we  in  1  MTC0 write strobe, qualified by cp0_addr.
- cp0_addr  in  6  CP0 register select for both write and read.
- mtc0_data  in  32  MTC0 write data.
- status_ie  in  1  Status.IE.
- status_exl  in  1  Status.EXL.
- status_im7  in  1  Status.IM[7].
- freeze  in  1  debug/stall freeze request (used only with the optional feature).
- rdata  out  32  MFC0 read data.
- count_o  out  32  current Count.
- compare_o  out  32  current Compare.
- cause_ti  out  1  Cause.TI pending bit.
- timer_irq  out  1  masked timer interrupt request.

Behaviour:
- Reset (rst_n=0 at posedge):
  - count_o=COUNT_INI, compare_o=COMPARE_INI.
  - tick=0, cause_ti=0, state=DISARMED.
- tick: toggles every cycle. Count increments (mod 2^32) on each cycle where tick=1, so one increment per 2 cycles. 32'hFFFF_FFFF wraps to 0 without side effects.
- Count write: mtc0_we && cp0_addr==ADDR_COUNT loads mtc0_data at the next edge.
  - Has priority over the increment.
  - Forces tick to 0, so the first increment after the write lands 2 edges later.
  - Does not change cause_ti or state.
- Compare write: mtc0_we && cp0_addr==ADDR_COMPARE loads compare_o, clears cause_ti and sets state=ARMED, all at the next edge.
- FSM states: DISARMED, ARMED, PENDING.
  - DISARMED -> ARMED on Compare write. Matches are ignored in DISARMED.
  - ARMED -> PENDING when count_o==compare_o at a posedge and no Compare write occurs that cycle. cause_ti=1 at that same edge.
  - PENDING -> ARMED only on Compare write (cause_ti cleared). Further matches have no effect.
- Simultaneous events:
  - A Compare write and a match in the same cycle: the write wins. Result is ARMED with cause_ti=0.
  - A Count write that makes Count equal Compare: the match is detected on the following edge.
- Single-shot: Count holds each value for 2 cycles, but a match fires exactly once per arming.
- timer_irq = cause_ti & status_ie & ~status_exl & status_im7. Combinational from registered state; no added latency.
- rdata (combinational):
  - count_o when cp0_addr==ADDR_COUNT.
  - compare_o when cp0_addr==ADDR_COMPARE.
  - 0 otherwise.
  - A write is visible on rdata the cycle after mtc0_we.
- Reset mid-operation overrides everything, including pending writes and PENDING state.

Optional Feature:
- Macro CP0_TIMER_FREEZE_EN.
- Defined:
  - While freeze=1, the tick flop and Count hold their values.
  - MTC0 writes still take effect.
  - Match detection still runs.
  - On release, incrementing resumes from the held tick phase.
- Undefined: the freeze input is ignored and Count always advances.

Test Plan:
- Reset, then 10 idle cycles -> count_o=5, cause_ti=0, state DISARMED, rdata with cp0_addr=9 is 5.
- Write Compare=8 at cycle 0 (Count=0, tick=0) -> cause_ti rises at the first edge where Count==8 and stays high; with status_ie=1, exl=0, im7=1, timer_irq=1; exl=1 -> timer_irq=0.
- Count=8, Compare=8 in PENDING, then write Compare=20 -> cause_ti=0 next cycle; Count written 20 -> cause_ti=1 on the following edge.
- Count write 32'hFFFF_FFFE, Compare=1 -> Count goes FFFF_FFFE, FFFF_FFFF, 0, 1 at 2-cycle steps; cause_ti sets when Count=1.
- Compare write coinciding with a match cycle -> cause_ti stays 0, state ARMED; Count write coinciding with tick=1 -> loaded value held 2 cycles.
- With CP0_TIMER_FREEZE_EN: freeze=1 for 7 cycles at Count=3 -> Count stays 3; a Count write of 40 during freeze -> count_o=40; after release, Count resumes incrementing.
